// File: rtl/debug_loader_if.sv
// ----------------------------------------------------------------------------
// debug_loader_if
// Groups the UART byte streams and the memory debug-port address/strobe used
// by debug_loader. The bidirectional debug data bus is kept as a plain inout
// port on the loader so the tri-state can be resolved at the top level.
//
// Signals:
//   rx_data[7:0]     received UART byte
//   rx_valid         one-cycle strobe qualifying rx_data
//   tx_data[7:0]     byte to transmit
//   tx_valid         qualifies tx_data
//   tx_ready         transmitter accepts a byte
//   debug_addr[31:0] byte address to the memory debug port
//   debug_we         debug-port write enable
//
// Handshake: rx is a plain strobe with no back-pressure (a byte is taken on
// every cycle rx_valid is high). tx follows valid/ready: a byte moves on a
// cycle where tx_valid && tx_ready; while tx_valid is high and tx_ready is low
// the sender holds tx_data and tx_valid unchanged.
//
// Modports:
//   slave  - the loader (consumes rx, produces tx and debug-port controls)
//   master - the environment (UART side and memory side)
// ----------------------------------------------------------------------------
interface debug_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] debug_addr;
    logic        debug_we;

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, debug_addr, debug_we
    );

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, debug_addr, debug_we
    );
endinterface

// File: rtl/debug_loader.sv
// ----------------------------------------------------------------------------
// debug_loader
// UART-driven debug loader. Accepts 'W' addr[4] data[4] (write word, answers
// ACK_BYTE), 'R' addr[4] (read word, answers 4 data bytes MSB-first) and 'G'
// (release the CPU). Any W/R command halts the CPU until a later 'G'.
// Bytes that stall for TIMEOUT_CYCLES mid-command abort it with an err pulse.
//
// Ports:
//   i_clk          clock, all state changes on its rising edge
//   i_rst          synchronous active-high reset
//   io_bus         debug_loader_if.slave (UART rx/tx, debug_addr, debug_we)
//   io_debug_data  32-bit debug data bus, driven only while debug_we=1
//   o_cpu_halt     holds the CPU stalled while high
//   o_busy         high in every state except IDLE
//   o_err          one-cycle pulse on a protocol error
//   o_dbg_state    current FSM state encoding (for observation)
// ----------------------------------------------------------------------------
module debug_loader #(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] CMD_WRITE      = 8'h57,
    parameter logic [7:0] CMD_READ       = 8'h52,
    parameter logic [7:0] CMD_GO         = 8'h47,
    parameter logic [7:0] ACK_BYTE       = 8'h4B
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    debug_loader_if.slave        io_bus,
    inout  wire  [31:0]          io_debug_data,
    output logic                 o_cpu_halt,
    output logic                 o_busy,
    output logic                 o_err,
    output logic [2:0]           o_dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_RD_REQ, S_RD_CAP, S_TX_WORD, S_TX_ACK
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_is_write;
    logic [1:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic          r_halt;
    logic          r_err;
    logic [TW-1:0] r_timer;

    logic          w_err;
    logic          w_we;
    logic          w_tx_valid;
    logic [7:0]    w_tx_data;
    logic [7:0]    w_word_byte;
    logic          w_tx_fire;
    logic          w_cmd_rw;
    logic          w_timeout;

    assign w_cmd_rw  = (io_bus.rx_data == CMD_WRITE) || (io_bus.rx_data == CMD_READ);
    assign w_tx_fire = w_tx_valid && io_bus.tx_ready;
    // Fires on the idle cycle that would make the count reach TIMEOUT_CYCLES.
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Byte of the data register selected by the transmit counter, MSB first.
    always_comb begin
        w_word_byte = 8'h00;
        case (r_cnt)
            2'd0: w_word_byte = r_data[31:24];
            2'd1: w_word_byte = r_data[23:16];
            2'd2: w_word_byte = r_data[15:8];
            2'd3: w_word_byte = r_data[7:0];
            default: w_word_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_we         = 1'b0;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (io_bus.rx_valid) begin
                    if (w_cmd_rw) begin
                        w_state_next = S_ADDR;
                    end else if (io_bus.rx_data != CMD_GO) begin
                        w_err = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (io_bus.rx_valid) begin
                    if (r_cnt == 2'd3) begin
                        w_state_next = r_is_write ? S_DATA : S_RD_REQ;
                    end
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (io_bus.rx_valid) begin
                    if (r_cnt == 2'd3) begin
                        w_state_next = S_WRITE;
                    end
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                w_we         = 1'b1;
                w_err        = io_bus.rx_valid;
                w_state_next = S_TX_ACK;
            end
            S_RD_REQ: begin
                w_err        = io_bus.rx_valid;
                w_state_next = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_err        = io_bus.rx_valid;
                w_state_next = S_TX_WORD;
            end
            S_TX_WORD: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_word_byte;
                w_err      = io_bus.rx_valid;
                if (w_tx_fire && (r_cnt == 2'd3)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_TX_ACK: begin
                w_tx_valid = 1'b1;
                w_tx_data  = ACK_BYTE;
                w_err      = io_bus.rx_valid;
                if (w_tx_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_is_write <= 1'b0;
            r_cnt      <= 2'd0;
            r_addr     <= 32'h0;
            r_data     <= 32'h0;
            r_halt     <= 1'b1;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.rx_valid) begin
                        if (w_cmd_rw) begin
                            r_is_write <= (io_bus.rx_data == CMD_WRITE);
                            r_halt     <= 1'b1;
                            r_cnt      <= 2'd0;
                            r_timer    <= '0;
                        end else if (io_bus.rx_data == CMD_GO) begin
                            r_halt <= 1'b0;
                        end
                    end
                end
                S_ADDR: begin
                    if (io_bus.rx_valid) begin
                        r_addr  <= {r_addr[23:0], io_bus.rx_data};
                        r_cnt   <= r_cnt + 2'd1;   // wraps to 0 for the next phase
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (io_bus.rx_valid) begin
                        r_data  <= {r_data[23:0], io_bus.rx_data};
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RD_CAP: begin
                    r_data <= io_debug_data;
                end
                S_TX_WORD: begin
                    if (w_tx_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_debug_data     = w_we ? r_data : 32'bz;
    assign io_bus.debug_we   = w_we;
    assign io_bus.debug_addr = r_addr;
    assign io_bus.tx_valid   = w_tx_valid;
    assign io_bus.tx_data    = w_tx_data;
    assign o_cpu_halt        = r_halt;
    assign o_busy            = (r_state != S_IDLE);
    assign o_err             = r_err;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_debug_loader.sv
// ----------------------------------------------------------------------------
// tb_debug_loader
// Drives byte-level commands into debug_loader, models a small word memory on
// the debug port, and compares transmitted bytes, memory writes, err pulses
// and cpu_halt against a command-level reference model.
// ----------------------------------------------------------------------------
module tb_debug_loader;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        cpu_halt;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_state;
    wire  [31:0] debug_data;

    debug_loader_if bus ();

    debug_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .io_bus        (bus),
        .io_debug_data (debug_data),
        .o_cpu_halt    (cpu_halt),
        .o_busy        (busy),
        .o_err         (err),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory on the debug port ----------------
    logic [31:0] dev_mem [0:255];
    logic [31:0] mem_model [0:255];

    function automatic logic [7:0] idx(input logic [31:0] a);
        return {a[14], a[8:2]};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h01030507) ^ 32'hA5C3_0F96;
    endfunction

    assign debug_data = bus.debug_we ? 32'bz : dev_mem[{bus.debug_addr[14], bus.debug_addr[8:2]}];

    // ---------------- monitors ----------------
    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    int          err_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= pat(i);
        end else begin
            if (bus.debug_we) begin
                dev_mem[{bus.debug_addr[14], bus.debug_addr[8:2]}] <= debug_data;
                wr_q.push_back({bus.debug_addr, debug_data});
            end
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (err) err_cnt++;
        end
    end

    // ---------------- scoreboard / model state ----------------
    logic [7:0]  exp_q[$];
    logic [63:0] exp_wr_q[$];
    int          exp_err = 0;
    bit          model_halt = 1'b1;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        model_halt = 1'b1;
        for (int i = 0; i < 256; i++) mem_model[i] = pat(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Caller sits just after a falling edge; the byte is seen on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit rnd, input bit stray, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            bus.tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stray && $urandom_range(0, 7) == 0) begin
                bus.rx_data  = 8'($urandom);
                bus.rx_valid = 1'b1;
                exp_err++;
            end
            @(negedge clk);
            bus.rx_valid = 1'b0;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_sb(input string tag);
        int ntx;
        int nwr;
        repeat (2) @(negedge clk);
        check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_q.size()));
        ntx = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < ntx; i++) check({tag, "_tx_byte"}, 32'(tx_q[i]), 32'(exp_q[i]));
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr_q.size()));
        nwr = (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
        for (int i = 0; i < nwr; i++) begin
            check({tag, "_wr_addr"}, wr_q[i][63:32], exp_wr_q[i][63:32]);
            check({tag, "_wr_data"}, wr_q[i][31:0], exp_wr_q[i][31:0]);
        end
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "_halt"}, 32'(cpu_halt), 32'(model_halt));
        tx_q.delete();
        wr_q.delete();
        exp_q.delete();
        exp_wr_q.delete();
    endtask

    // Full W or R command; the model decides the reply from the command alone.
    task automatic run_cmd(input string tag, input bit is_wr, input logic [31:0] a,
                           input logic [31:0] d, input int gap_max, input bit rnd);
        logic [31:0] w;
        model_halt = 1'b1;
        if (is_wr) begin
            mem_model[idx(a)] = d;
            exp_wr_q.push_back({a, d});
            exp_q.push_back(8'h4B);
        end else begin
            w = mem_model[idx(a)];
            for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
        end
        send_byte(is_wr ? 8'h57 : 8'h52, $urandom_range(0, gap_max));
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], $urandom_range(0, gap_max));
        if (is_wr) begin
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], $urandom_range(0, gap_max));
        end
        wait_idle(tag, rnd, rnd, 300);
        check_sb(tag);
    endtask

    // Global guard so the run always ends.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        int          stall;
        int          n;
        int          r;

        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data), 32'd0);
        check("rst_we",       32'(bus.debug_we), 32'd0);
        check("rst_addr",     bus.debug_addr, 32'd0);
        check("rst_halt",     32'(cpu_halt), 32'd1);
        check("rst_state",    32'(dbg_state), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Halt control: G releases, R re-halts at once, then R aborts on timeout.
        send_byte(8'h47, 0);
        check("go_halt", 32'(cpu_halt), 32'd0);
        send_byte(8'h52, 0);
        check("rd_halt_now", 32'(cpu_halt), 32'd1);
        model_halt = 1'b1;
        exp_err++;
        wait_idle("rd_timeout", 1'b0, 1'b0, 4 * TMO);
        check("rd_timeout_state", 32'(dbg_state), 32'd0);
        check_sb("rd_timeout");

        // Directed write.
        run_cmd("wr_4010", 1'b1, 32'h0000_4010, 32'hDEAD_BEEF, 0, 1'b0);

        // Directed read with a 5-cycle transmitter stall before byte 2.
        run_cmd("wr_0010", 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 1'b0);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        send_byte(8'h52, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        stall = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (tx_q.size() == 1 && stall < 5) begin
                bus.tx_ready = 1'b0;
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data",  32'(bus.tx_data), 32'h34);
                stall++;
            end else begin
                bus.tx_ready = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        check("stall_cycles", 32'(stall), 32'd5);
        check("rd_0010_idle", 32'(busy), 32'd0);
        check_sb("rd_0010");

        // Unknown byte in IDLE.
        send_byte(8'h58, 0);
        exp_err++;
        check_sb("bad_cmd");

        // Write aborted by silence after two address bytes.
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        exp_err++;
        wait_idle("wr_timeout", 1'b0, 1'b0, 4 * TMO);
        check("wr_timeout_state", 32'(dbg_state), 32'd0);
        check_sb("wr_timeout");

        // Reset in the middle of the data phase, then a clean write.
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        send_byte(8'h10, 0);
        send_byte(8'hDE, 0);
        do_reset();
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check_sb("mid_rst");
        run_cmd("post_rst_wr", 1'b1, 32'h0000_4010, 32'hCAFE_F00D, 0, 1'b0);

        // Randomized mix of commands, bus stalls and stray bytes.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_byte(8'h47, $urandom_range(0, 4));
                model_halt = 1'b0;
                check_sb("rnd_go");
            end else if (r == 1) begin
                do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h47);
                send_byte(b, $urandom_range(0, 4));
                exp_err++;
                check_sb("rnd_bad");
            end else begin
                if ($urandom_range(0, 1) == 1) a = $urandom;
                else a = (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 14);
                run_cmd("rnd_cmd", ($urandom_range(0, 1) == 1), a, $urandom, 8, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
